// File: rtl/display_pkg.sv
// Shared constants and types for the clock display scan path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

  // Digit codes understood by the seven-segment decoder beyond 0-9.
  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_ERR   = 4'hB;

  localparam int NUM_DIGITS = 4;

  // Digit slot indices; slot 0 is the rightmost digit.
  localparam logic [1:0] MIN_ONES = 2'd0;
  localparam logic [1:0] MIN_TENS = 2'd1;
  localparam logic [1:0] HR_ONES  = 2'd2;
  localparam logic [1:0] HR_TENS  = 2'd3;

  // Registered output bundle driven towards the decoder and digit drivers.
  typedef struct packed {
    logic [3:0] code;
    logic [3:0] anode_n;
    logic [1:0] sel;
  } scan_out_t;

  localparam scan_out_t OUT_RESET = '{code: CODE_BLANK, anode_n: 4'b1111, sel: MIN_ONES};

  // Active-low one-hot enable for a digit slot.
  function automatic logic [3:0] onehot_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Bus between the time/alarm logic, the scanner and the segment decoder.
// Latency: n/a (wiring only).
// Backpressure: none; the scanner free-runs and inputs are sampled at scan ticks.
interface display_scan_if;
  import display_pkg::*;

  logic [15:0]           digits_in;
  logic                  load;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic                  blank_lz;
  logic                  display_en;
  logic [3:0]            digit_code;
  logic [NUM_DIGITS-1:0] anode_n;
  logic [1:0]            digit_sel;

  // Time/alarm side: supplies digits and display controls, observes the scan.
  modport master (
    output digits_in, load, blink_mask, blank_lz, display_en,
    input  digit_code, anode_n, digit_sel
  );

  // Scanner side.
  modport slave (
    input  digits_in, load, blink_mask, blank_lz, display_en,
    output digit_code, anode_n, digit_sel
  );
endinterface

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter that emits a one-cycle tick on its last count.
// Latency: tick is combinational from the count register, asserted when count = DIV-1 and en = 1.
// Backpressure: none; counting only advances while en is high.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Advance while enabled, wrapping to zero on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 4-digit scanner: shadow capture, blanking, blinking and error coding.
// Latency: outputs change one cycle after each scan tick; a load is seen at the next tick.
// Backpressure: none; scanning free-runs even while the display is disabled.
module display_scan
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 128
) (
  input  logic           clk,
  input  logic           reset,
  display_scan_if.slave  bus
);

  logic        scan_tick;
  logic        blink_wrap;
  logic [15:0] shadow_q, shadow_d;
  logic [1:0]  idx_q, idx_d, idx_nxt;
  logic        blink_phase_q, blink_phase_d;
  scan_out_t   out_q, out_d;
  logic [3:0]  nibble;
  logic [3:0]  code_nxt;

  // Scan-rate prescaler.
  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .tick  (scan_tick)
  );

  // Blink half-period counter, stepped once per scan slot.
  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk   (clk),
    .reset (reset),
    .en    (scan_tick),
    .tick  (blink_wrap)
  );

  // The slot being prepared is the one after the current index; the shadow
  // read here is the pre-load value, so a coincident load lands one tick later.
  assign idx_nxt = idx_q + 2'd1;
  assign nibble  = shadow_q[{idx_nxt, 2'b00} +: 4];

  // Digit code for the upcoming slot, highest-priority rule first.
  always_comb begin
    code_nxt = nibble;
    if (!bus.display_en) begin
      code_nxt = CODE_BLANK;
    end else if (blink_phase_q && bus.blink_mask[idx_nxt]) begin
      code_nxt = CODE_BLANK;
    end else if ((idx_nxt == HR_TENS) && bus.blank_lz && (nibble == 4'd0)) begin
      code_nxt = CODE_BLANK;
    end else if (nibble > 4'd9) begin
      code_nxt = CODE_ERR;
    end
  end

  // Next-state for shadow, index, blink phase and the registered outputs.
  always_comb begin
    shadow_d      = bus.load ? bus.digits_in : shadow_q;
    idx_d         = idx_q;
    blink_phase_d = blink_phase_q ^ blink_wrap;
    out_d         = out_q;
    if (scan_tick) begin
      idx_d         = idx_nxt;
      out_d.sel     = idx_nxt;
      out_d.code    = code_nxt;
      out_d.anode_n = bus.display_en ? onehot_low(idx_nxt) : 4'b1111;
    end
  end

  // State registers; reset clears everything including the captured digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q      <= 16'h0000;
      idx_q         <= MIN_ONES;
      blink_phase_q <= 1'b0;
      out_q         <= OUT_RESET;
    end else begin
      shadow_q      <= shadow_d;
      idx_q         <= idx_d;
      blink_phase_q <= blink_phase_d;
      out_q         <= out_d;
    end
  end

  assign bus.digit_code = out_q.code;
  assign bus.anode_n    = out_q.anode_n;
  assign bus.digit_sel  = out_q.sel;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan with SCAN_DIV=4, BLINK_DIV=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_display_scan;

  localparam int SD = 4;
  localparam int BD = 2;

  logic clk = 1'b0;
  logic reset;

  display_scan_if bus();

  display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  // Tick k (counted from reset release) happens on the k*SD-th rising edge;
  // it shows slot k mod 4, with blink phase = number of completed blink
  // half-periods before that tick, modulo 2.
  int         m_cyc;
  int         m_ticks;
  logic [15:0] m_shadow;
  logic [3:0] m_code;
  logic [3:0] m_anode;
  logic [1:0] m_sel;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin : model
    int d;
    int ph;
    logic [3:0] nib;
    if (reset) begin
      m_cyc    = 0;
      m_ticks  = 0;
      m_shadow = 16'h0000;
      m_code   = 4'hA;
      m_anode  = 4'b1111;
      m_sel    = 2'd0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      m_cyc = m_cyc + 1;
      if (m_cyc % SD == 0) begin
        m_ticks = m_ticks + 1;
        d   = m_ticks % 4;
        ph  = ((m_ticks - 1) / BD) % 2;
        nib = 4'(m_shadow >> (4 * d));
        m_sel = 2'(d);
        if (!bus.display_en) begin
          m_code  = 4'hA;
          m_anode = 4'b1111;
        end else begin
          m_anode    = 4'b1111;
          m_anode[d] = 1'b0;
          if (ph == 1 && bus.blink_mask[d])            m_code = 4'hA;
          else if (d == 3 && bus.blank_lz && nib == 0) m_code = 4'hA;
          else if (nib > 4'd9)                         m_code = 4'hB;
          else                                         m_code = nib;
        end
      end
      if (bus.load) m_shadow = bus.digits_in;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp = n_cmp + 1;
      if (bus.digit_code !== m_code || bus.anode_n !== m_anode || bus.digit_sel !== m_sel) begin
        n_bad = n_bad + 1;
        $display("FAIL model_cmp t=%0t: got code=%h anode_n=%b sel=%0d, want code=%h anode_n=%b sel=%0d",
                 $time, bus.digit_code, bus.anode_n, bus.digit_sel, m_code, m_anode, m_sel);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Advance to the negedge just after the next scan tick (bounded).
  task automatic next_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while ((m_cyc % SD) != 0 && n < 4 * SD);
    if ((m_cyc % SD) != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL tick_timeout t=%0t: got no tick within %0d cycles want a tick", $time, n);
    end
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.digits_in = v;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  // Run four ticks, checking each slot's code against a per-slot table.
  task automatic scan_check(input string name, input logic [3:0] e0, input logic [3:0] e1,
                            input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] exp_tab [4];
    exp_tab[0] = e0; exp_tab[1] = e1; exp_tab[2] = e2; exp_tab[3] = e3;
    for (int i = 0; i < 4; i++) begin
      next_tick();
      chk(name, bus.digit_code, exp_tab[bus.digit_sel]);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset          = 1'b1;
    bus.digits_in  = 16'h0000;
    bus.load       = 1'b0;
    bus.blink_mask = 4'b0000;
    bus.blank_lz   = 1'b0;
    bus.display_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_code",  bus.digit_code, 4'hA);
    chk("reset_anode", bus.anode_n,    4'b1111);
    chk("reset_sel",   {2'b00, bus.digit_sel}, 4'd0);

    // First tick lands on the 4th edge after release.
    reset          = 1'b0;
    bus.display_en = 1'b1;
    bus.digits_in  = 16'h1234;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("pre_tick_sel", {2'b00, bus.digit_sel}, 4'd0);
    repeat (2) @(negedge clk);
    chk("pre_tick_code", bus.digit_code, 4'hA);
    @(negedge clk);
    chk("first_sel",   {2'b00, bus.digit_sel}, 4'd1);
    chk("first_code",  bus.digit_code, 4'd3);
    chk("first_anode", bus.anode_n,    4'b1101);
    next_tick(); chk("sel2_code", bus.digit_code, 4'd2);
    next_tick(); chk("sel3_code", bus.digit_code, 4'd1);
    next_tick(); chk("sel0_code", bus.digit_code, 4'd4);
    chk("sel0_anode", bus.anode_n, 4'b1110);

    // Leading-zero blanking.
    bus.blank_lz = 1'b1;
    load_val(16'h0705);
    scan_check("lz_on", 4'd5, 4'd0, 4'd7, 4'hA);
    bus.blank_lz = 1'b0;
    scan_check("lz_off", 4'd5, 4'd0, 4'd7, 4'd0);

    // Invalid nibble on minutes tens.
    load_val(16'h12C4);
    scan_check("err_digit", 4'd4, 4'hB, 4'd2, 4'd1);

    // Blinking on the hour digits: with these dividers slot 3 always meets
    // blink phase 1 and slot 2 always phase 0.
    load_val(16'h1234);
    bus.blink_mask = 4'b1100;
    scan_check("blink", 4'd4, 4'd3, 4'd2, 4'hA);
    bus.blink_mask = 4'b0000;

    // Load coincident with a tick: the old nibble is shown first.
    for (int i = 0; i < 4 && m_sel != 2'd0; i++) next_tick();
    repeat (3) @(negedge clk);
    bus.digits_in = 16'h5678;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("ldtick_sel",  {2'b00, bus.digit_sel}, 4'd1);
    chk("ldtick_old",  bus.digit_code, 4'd3);
    next_tick();
    chk("ldtick_new",  bus.digit_code, 4'd6);

    // Display disabled: anodes off, scan keeps moving.
    bus.display_en = 1'b0;
    next_tick();
    chk("dis_sel3",  {2'b00, bus.digit_sel}, 4'd3);
    chk("dis_code",  bus.digit_code, 4'hA);
    chk("dis_anode", bus.anode_n, 4'b1111);
    next_tick();
    chk("dis_sel0",  {2'b00, bus.digit_sel}, 4'd0);
    bus.display_en = 1'b1;
    next_tick();
    chk("reen_code",  bus.digit_code, 4'd7);
    chk("reen_anode", bus.anode_n, 4'b1101);

    // Reset in the middle of the scan.
    next_tick();
    chk("pre_rst_sel", {2'b00, bus.digit_sel}, 4'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_sel",   {2'b00, bus.digit_sel}, 4'd0);
    chk("rst_code",  bus.digit_code, 4'hA);
    chk("rst_anode", bus.anode_n, 4'b1111);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wait_sel", {2'b00, bus.digit_sel}, 4'd0);
    @(negedge clk);
    chk("rst_first_sel",  {2'b00, bus.digit_sel}, 4'd1);
    chk("rst_shadow_clr", bus.digit_code, 4'd0);

    repeat (8) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
